// File: rtl/formacao_inimigos.sv
// Enemy formation: block movement with edge reversal and drop, speed-up on kills, shot hit test and scoring.
// Outputs are registered and update one cycle after the inputs; there is no backpressure, and pausa freezes movement and shots.
module formacao_inimigos #(
  parameter int N_COLS    = 5,
  parameter int N_ROWS    = 3,
  parameter int X0        = 100,
  parameter int Y0        = 40,
  parameter int DX        = 100,
  parameter int DY        = 40,
  parameter int LARG      = 33,
  parameter int ALT       = 24,
  parameter int STEP_X    = 4,
  parameter int STEP_Y    = 16,
  parameter int X_MAX     = 640,
  parameter int Y_LIMITE  = 400,
  parameter int PER_MIN   = 200000,
  parameter int PER_PASSO = 50000
) (
  input  logic                     CLOCK_50,
  input  logic                     reset,
  input  logic                     pausa,
  input  logic                     reiniciarJogo,
  input  logic                     tiro_valido,
  input  logic [9:0]               tiro_x,
  input  logic [9:0]               tiro_y,
  output logic [9:0]               form_x,
  output logic [9:0]               form_y,
  output logic [N_ROWS*N_COLS-1:0] vivo,
  output logic                     acerto,
  output logic [4:0]               acerto_idx,
  output logic [15:0]              pontos,
  output logic                     todos_mortos,
  output logic                     invadiu
);

  localparam int N = N_ROWS * N_COLS;

  typedef enum logic {ESQUERDA, DIREITA} sentido_t;

  sentido_t          sentido, prox_sentido;
  logic [31:0]       cnt, periodo;
  logic [5:0]        n_vivos;
  logic [N_COLS-1:0] col_viva;
  logic [N_ROWS-1:0] lin_viva;
  logic [3:0]        cmax, cmin;
  logic [2:0]        rmax;
  logic              conta, passo, invasao;
  logic [10:0]       fx11, fy11, tx11, ty11, borda_dir, borda_esq;
  logic [9:0]        prox_fx, prox_fy;
  logic [10:0]       ex, ey;
  logic              acha;
  logic [4:0]        acha_idx;
  logic [15:0]       acha_pts;
  logic [N-1:0]      mata;
  logic [16:0]       soma;

  assign fx11 = {1'b0, form_x};
  assign fy11 = {1'b0, form_y};
  assign tx11 = {1'b0, tiro_x};
  assign ty11 = {1'b0, tiro_y};

  always_comb begin
    n_vivos  = '0;
    col_viva = '0;
    lin_viva = '0;
    for (int i = 0; i < N; i++) begin
      n_vivos = n_vivos + 6'(vivo[i]);
      if (vivo[i]) begin
        col_viva[i % N_COLS] = 1'b1;
        lin_viva[i / N_COLS] = 1'b1;
      end
    end
  end

  // Extents of the live block; all default to 0 when nobody is left.
  always_comb begin
    cmax = '0;
    cmin = '0;
    rmax = '0;
    for (int c = 0; c < N_COLS; c++)
      if (col_viva[c]) cmax = 4'(c);
    for (int c = N_COLS - 1; c >= 0; c--)
      if (col_viva[c]) cmin = 4'(c);
    for (int r = 0; r < N_ROWS; r++)
      if (lin_viva[r]) rmax = 3'(r);
  end

  assign periodo = 32'(PER_MIN) + 32'(n_vivos) * 32'(PER_PASSO);
  assign conta   = !pausa && !todos_mortos && !invadiu;
  assign passo   = conta && (cnt >= periodo - 32'd1);

  assign borda_dir = fx11 + 11'(int'(cmax) * DX) + 11'(LARG + STEP_X);
  assign borda_esq = fx11 + 11'(int'(cmin) * DX);

  always_comb begin
    prox_fx      = form_x;
    prox_fy      = form_y;
    prox_sentido = sentido;
    if (sentido == DIREITA) begin
      if (borda_dir > 11'(X_MAX)) begin
        prox_sentido = ESQUERDA;
        prox_fy      = form_y + 10'(STEP_Y);
      end else begin
        prox_fx = form_x + 10'(STEP_X);
      end
    end else begin
      if (borda_esq < 11'(STEP_X)) begin
        prox_sentido = DIREITA;
        prox_fy      = form_y + 10'(STEP_Y);
      end else begin
        prox_fx = form_x - 10'(STEP_X);
      end
    end
  end

  assign invasao = ({1'b0, prox_fy} + 11'(int'(rmax) * DY) + 11'(ALT)) >= 11'(Y_LIMITE);

  // Scan from index 0 upward so the lowest live enemy under the shot wins.
  always_comb begin
    acha     = 1'b0;
    acha_idx = '0;
    acha_pts = '0;
    mata     = '0;
    ex       = '0;
    ey       = '0;
    if (tiro_valido && !pausa && !todos_mortos) begin
      for (int i = 0; i < N; i++) begin
        ex = fx11 + 11'((i % N_COLS) * DX);
        ey = fy11 + 11'((i / N_COLS) * DY);
        if (!acha && vivo[i] && tx11 >= ex && tx11 < ex + 11'(LARG) &&
            ty11 >= ey && ty11 < ey + 11'(ALT)) begin
          acha     = 1'b1;
          acha_idx = 5'(i);
          acha_pts = 16'(10 * (N_ROWS - i / N_COLS));
          mata[i]  = 1'b1;
        end
      end
    end
  end

  assign soma = {1'b0, pontos} + {1'b0, acha_pts};

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      form_x       <= 10'(X0);
      form_y       <= 10'(Y0);
      vivo         <= '1;
      pontos       <= '0;
      acerto       <= 1'b0;
      acerto_idx   <= '0;
      todos_mortos <= 1'b0;
      invadiu      <= 1'b0;
      sentido      <= DIREITA;
      cnt          <= '0;
    end else if (reiniciarJogo) begin
      form_x       <= 10'(X0);
      form_y       <= 10'(Y0);
      vivo         <= '1;
      pontos       <= '0;
      acerto       <= 1'b0;
      acerto_idx   <= '0;
      todos_mortos <= 1'b0;
      invadiu      <= 1'b0;
      sentido      <= DIREITA;
      cnt          <= '0;
    end else begin
      acerto <= acha;
      if (acha) begin
        vivo       <= vivo & ~mata;
        acerto_idx <= acha_idx;
        pontos     <= soma[16] ? 16'hFFFF : soma[15:0];
      end
      todos_mortos <= (vivo == '0);
      if (conta) begin
        if (passo) begin
          cnt     <= '0;
          form_x  <= prox_fx;
          form_y  <= prox_fy;
          sentido <= prox_sentido;
          if (invasao) invadiu <= 1'b1;
        end else begin
          cnt <= cnt + 32'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_formacao_inimigos.sv
// Bench for formacao_inimigos: vector table, directed corner sequences and random lockstep against a rule-level model.
module tb_formacao_inimigos;

  localparam int NC = 5, NR = 3, N = 15;
  localparam int PMIN = 4, PPASSO = 1;
  localparam int DX = 100, DY = 40, LARG = 33, ALT = 24;
  localparam int STEPX = 4, STEPY = 16, XMAX = 640, YLIM = 400;

  logic          CLOCK_50 = 1'b0;
  logic          reset = 1'b1;
  logic          pausa = 1'b0;
  logic          reiniciarJogo = 1'b0;
  logic          tiro_valido = 1'b0;
  logic [9:0]    tiro_x = '0, tiro_y = '0;
  logic [9:0]    form_x, form_y;
  logic [N-1:0]  vivo;
  logic          acerto;
  logic [4:0]    acerto_idx;
  logic [15:0]   pontos;
  logic          todos_mortos, invadiu;

  formacao_inimigos #(.N_COLS(NC), .N_ROWS(NR), .PER_MIN(PMIN), .PER_PASSO(PPASSO)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .pausa(pausa), .reiniciarJogo(reiniciarJogo),
    .tiro_valido(tiro_valido), .tiro_x(tiro_x), .tiro_y(tiro_y),
    .form_x(form_x), .form_y(form_y), .vivo(vivo), .acerto(acerto), .acerto_idx(acerto_idx),
    .pontos(pontos), .todos_mortos(todos_mortos), .invadiu(invadiu)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int m_fx, m_fy, m_cnt, m_pts, m_idx;
  bit m_dir, m_acerto, m_todos, m_inv;
  bit m_vivo [N];

  typedef struct {
    logic pz;
    int   tx, ty;
    logic hit;
    int   idx;
    int   pts;
  } vec_t;
  vec_t vt [11];

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_fx = 100; m_fy = 40; m_dir = 1; m_cnt = 0; m_pts = 0; m_idx = 0;
    m_acerto = 0; m_todos = 0; m_inv = 0;
    foreach (m_vivo[i]) m_vivo[i] = 1;
  endtask

  function automatic int n_alive();
    int n = 0;
    foreach (m_vivo[i]) n += int'(m_vivo[i]);
    return n;
  endfunction

  task automatic model_eval();
    int nv, per, cmax, cmin, rmax, ex, ey, hi, tx, ty;
    bit hit;
    if (reiniciarJogo) begin
      model_reset();
      return;
    end
    nv  = n_alive();
    per = PMIN + nv * PPASSO;
    tx  = int'(tiro_x);
    ty  = int'(tiro_y);
    hit = 0; hi = 0;
    if (tiro_valido && !pausa && !m_todos)
      for (int i = 0; i < N; i++) begin
        ex = m_fx + (i % NC) * DX;
        ey = m_fy + (i / NC) * DY;
        if (!hit && m_vivo[i] && tx >= ex && tx < ex + LARG && ty >= ey && ty < ey + ALT) begin
          hit = 1; hi = i;
        end
      end
    if (!pausa && !m_todos && !m_inv) begin
      if (m_cnt >= per - 1) begin
        m_cnt = 0;
        cmax = 0; cmin = -1; rmax = 0;
        for (int i = 0; i < N; i++)
          if (m_vivo[i]) begin
            if (i % NC > cmax) cmax = i % NC;
            if (cmin < 0 || i % NC < cmin) cmin = i % NC;
            if (i / NC > rmax) rmax = i / NC;
          end
        if (cmin < 0) cmin = 0;
        if (m_dir) begin
          if (m_fx + cmax * DX + LARG + STEPX > XMAX) begin m_dir = 0; m_fy += STEPY; end
          else m_fx += STEPX;
        end else begin
          if (m_fx + cmin * DX < STEPX) begin m_dir = 1; m_fy += STEPY; end
          else m_fx -= STEPX;
        end
        m_fx = m_fx & 1023;
        m_fy = m_fy & 1023;
        if (m_fy + rmax * DY + ALT >= YLIM) m_inv = 1;
      end else begin
        m_cnt++;
      end
    end
    m_todos  = (nv == 0);
    m_acerto = hit;
    if (hit) begin
      m_vivo[hi] = 0;
      m_idx = hi;
      m_pts += 10 * (NR - hi / NC);
      if (m_pts > 65535) m_pts = 65535;
    end
  endtask

  task automatic check_all(input string nm);
    logic [N-1:0] ev;
    bit ok;
    for (int i = 0; i < N; i++) ev[i] = m_vivo[i];
    ok = (int'(form_x) == m_fx) && (int'(form_y) == m_fy) && (vivo == ev) &&
         (acerto == m_acerto) && (!m_acerto || int'(acerto_idx) == m_idx) &&
         (int'(pontos) == m_pts) && (todos_mortos == m_todos) && (invadiu == m_inv);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s @%0t: got form=(%0d,%0d) vivo=%h acerto=%0d idx=%0d pontos=%0d todos=%0d inv=%0d; expected form=(%0d,%0d) vivo=%h acerto=%0d idx=%0d pontos=%0d todos=%0d inv=%0d",
               nm, $time, form_x, form_y, vivo, acerto, acerto_idx, pontos, todos_mortos, invadiu,
               m_fx, m_fy, ev, m_acerto, m_idx, m_pts, m_todos, m_inv);
    end
  endtask

  task automatic tick();
    model_eval();
    @(posedge CLOCK_50);
    #1;
    check_all("lockstep");
  endtask

  task automatic restart();
    tiro_valido = 0; pausa = 0; reiniciarJogo = 1;
    tick();
    reiniciarJogo = 0;
  endtask

  task automatic shoot_at(input int e, input int ox, input int oy);
    tiro_valido = 1;
    tiro_x = 10'(m_fx + (e % NC) * DX + ox);
    tiro_y = 10'(m_fy + (e / NC) * DY + oy);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, maxx, sx, sy, found;
    logic [N-1:0] ev;

    vt[0]  = '{1'b0, 102, 42,  1'b1, 0,  30};
    vt[1]  = '{1'b0, 100, 40,  1'b1, 0,  30};
    vt[2]  = '{1'b0, 132, 63,  1'b1, 0,  30};
    vt[3]  = '{1'b0, 133, 42,  1'b0, 0,  0};
    vt[4]  = '{1'b0, 102, 64,  1'b0, 0,  0};
    vt[5]  = '{1'b0, 99,  40,  1'b0, 0,  0};
    vt[6]  = '{1'b0, 302, 82,  1'b1, 7,  20};
    vt[7]  = '{1'b0, 502, 122, 1'b1, 14, 10};
    vt[8]  = '{1'b0, 532, 143, 1'b1, 14, 10};
    vt[9]  = '{1'b1, 102, 42,  1'b0, 0,  0};
    vt[10] = '{1'b0, 200, 42,  1'b1, 1,  30};

    // Reset state
    #2 reset = 0;
    model_reset();
    #1;
    check_all("reset");
    chk("reset_form_x", int'(form_x), 100);
    chk("reset_form_y", int'(form_y), 40);
    chk("reset_vivo", int'(vivo), 32'h7FFF);
    chk("reset_pontos", int'(pontos), 0);
    @(posedge CLOCK_50); #1;
    reset = 1;

    // First step latency with a full formation
    n = 0;
    while (int'(form_x) == 100 && n < 200) begin tick(); n++; end
    chk("first_step_cycles", n, PMIN + N * PPASSO);
    chk("first_step_x", int'(form_x), 104);

    // Shot vectors against the freshly restarted formation
    foreach (vt[k]) begin
      restart();
      pausa = vt[k].pz;
      tiro_valido = 1;
      tiro_x = 10'(vt[k].tx);
      tiro_y = 10'(vt[k].ty);
      tick();
      tiro_valido = 0; pausa = 0;
      chk($sformatf("vec%0d_acerto", k), int'(acerto), int'(vt[k].hit));
      if (vt[k].hit) chk($sformatf("vec%0d_idx", k), int'(acerto_idx), vt[k].idx);
      chk($sformatf("vec%0d_pontos", k), int'(pontos), vt[k].pts);
      ev = 15'h7FFF;
      if (vt[k].hit) ev[vt[k].idx] = 1'b0;
      chk($sformatf("vec%0d_vivo", k), int'(vivo), int'(ev));
    end

    // Full formation reaches the right edge at x=204
    restart();
    n = 0;
    while (int'(form_y) == 40 && n < 2000) begin tick(); n++; end
    chk("full_rev_x", int'(form_x), 204);
    chk("full_rev_y", int'(form_y), 56);

    // Column 4 dead: right reversal at x=304
    restart();
    tiro_valido = 1; tiro_x = 10'd502;
    tiro_y = 10'd42;  tick();
    tiro_y = 10'd82;  tick();
    tiro_y = 10'd122; tick();
    tiro_valido = 0;
    chk("col4_vivo", int'(vivo), 32'h3DEF);
    chk("col4_pontos", int'(pontos), 60);
    maxx = 0; n = 0;
    while (int'(form_y) == 40 && n < 3000) begin
      if (int'(form_x) > maxx) maxx = int'(form_x);
      tick(); n++;
    end
    chk("col4_rev_x", int'(form_x), 304);
    chk("col4_rev_y", int'(form_y), 56);
    chk("col4_max_x", maxx, 304);

    // Kill on the same cycle as a move step
    restart();
    found = 0;
    for (int k = 0; k < 100; k++) begin
      if (m_cnt == PMIN + n_alive() * PPASSO - 1) begin found = 1; break; end
      tick();
    end
    chk("tickhit_found", found, 1);
    shoot_at(6, 2, 2);
    tick();
    tiro_valido = 0;
    chk("tickhit_acerto", int'(acerto), 1);
    chk("tickhit_idx", int'(acerto_idx), 6);
    chk("tickhit_pontos", int'(pontos), 20);
    chk("tickhit_x", int'(form_x), 104);

    // Kill everyone; todos_mortos lags a cycle and movement freezes
    restart();
    for (int i = 0; i < N; i++) begin
      shoot_at(i, 5, 5);
      tick();
      chk($sformatf("killall_idx%0d", i), int'(acerto_idx), i);
    end
    tiro_valido = 0;
    chk("killall_vivo", int'(vivo), 0);
    chk("killall_todos_lag", int'(todos_mortos), 0);
    tick();
    chk("killall_todos", int'(todos_mortos), 1);
    chk("killall_pontos", int'(pontos), 300);
    sx = int'(form_x); sy = int'(form_y);
    repeat (40) tick();
    chk("killall_frozen_x", int'(form_x), sx);
    chk("killall_frozen_y", int'(form_y), sy);

    // Invasion with a full formation happens at form_y=296
    restart();
    n = 0;
    while (!invadiu && n < 25000) begin tick(); n++; end
    chk("inv_flag", int'(invadiu), 1);
    chk("inv_y", int'(form_y), 296);
    sx = int'(form_x);
    repeat (40) tick();
    chk("inv_frozen_x", int'(form_x), sx);
    chk("inv_sticky", int'(invadiu), 1);

    // Async reset mid-walk while paused
    restart();
    shoot_at(0, 2, 2);
    tick();
    tiro_valido = 0;
    repeat (40) tick();
    pausa = 1;
    #2 reset = 0;
    model_reset();
    #1;
    check_all("async_reset");
    chk("areset_form_x", int'(form_x), 100);
    chk("areset_vivo", int'(vivo), 32'h7FFF);
    chk("areset_pontos", int'(pontos), 0);
    chk("areset_acerto", int'(acerto), 0);
    @(posedge CLOCK_50); #1;
    reset = 1; pausa = 0;

    // Random lockstep
    for (int k = 0; k < 15000; k++) begin
      reiniciarJogo = ($urandom_range(0, 2999) == 0);
      pausa = ($urandom_range(0, 9) == 0);
      tiro_valido = $urandom_range(0, 1);
      if ($urandom_range(0, 1) == 1) begin
        shoot_at($urandom_range(0, N - 1), int'($urandom_range(0, 38)) - 3, int'($urandom_range(0, 29)) - 3);
        tiro_valido = $urandom_range(0, 1);
      end else begin
        tiro_x = 10'($urandom_range(0, 639));
        tiro_y = 10'($urandom_range(0, 479));
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
